// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O bus initiator.
// The parked address must never decode to a peripheral.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    WAIT,
    RESP
  } bus_init_state_t;

  localparam logic [15:0] IDLE_ADDRESS = 16'hFFFF;

endpackage

// File: rtl/bus_initiator.sv
// Single-command bus initiator: drives one bus access at a time,
// waits for the directional acknowledge or a timeout, then responds.
module bus_initiator
  import io_bus_pkg::*;
#(
  parameter int address_width = 16,
  parameter int data_width = 8,
  parameter logic [address_width-1:0] IdleAddress = IDLE_ADDRESS,
  parameter int TimeoutCycles = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [address_width-1:0] cmd_addr_i,
  input  logic [data_width-1:0]    cmd_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [data_width-1:0]    rsp_rdata_o,
  output logic                     rsp_error_o,
  output logic [address_width-1:0] address_o,
  output logic [data_width-1:0]    data_o,
  output logic                     rd_wr_o,
  input  logic [data_width-1:0]    data_i,
  input  logic                     take_controlr_i,
  input  logic                     take_controlw_i,
  output logic                     busy_o
);

  localparam int CW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TimeoutCycles - 1);

  bus_init_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [address_width-1:0] address_q, address_d;
  logic [data_width-1:0] data_q, data_d;
  logic rd_wr_q, rd_wr_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [data_width-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rsp_error_q, rsp_error_d;
  logic ack;

  // The bus registers double as the captured command while busy.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    address_d = address_q;
    data_d = data_q;
    rd_wr_d = rd_wr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    ack = rd_wr_q ? take_controlw_i : take_controlr_i;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = BUS;
          cnt_d = '0;
          address_d = cmd_addr_i;
          data_d = cmd_wdata_i;
          rd_wr_d = cmd_write_i;
        end
      end
      BUS: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ack || cnt_q == TO_LAST) begin
          state_d = RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = !ack;
          rsp_rdata_d = (ack && !rd_wr_q) ? data_i : '0;
          address_d = IdleAddress;
          data_d = '0;
          rd_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      address_q <= IdleAddress;
      data_q <= '0;
      rd_wr_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      address_q <= address_d;
      data_q <= data_d;
      rd_wr_q <= rd_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign address_o = address_q;
  assign data_o = data_q;
  assign rd_wr_o = rd_wr_q;

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- address_width, 16, bus address width.
- data_width, 8, bus data width.
- IdleAddress, 16'hFFFF, parked address; no peripheral is mapped here.
- TimeoutCycles, 16, maximum WAIT cycles before an error response.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, single clock; all logic is on its rising edge.
- reset_i, in, 1, synchronous, active-high reset.
- cmd_valid_i, in, 1, command offered.
- cmd_ready_o, out, 1, command accepted when high together with cmd_valid_i.
- cmd_write_i, in, 1, 1 = write, 0 = read.
- cmd_addr_i, in, address_width, target address.
- cmd_wdata_i, in, data_width, write data.
- rsp_valid_o, out, 1, response available.
- rsp_ready_i, in, 1, response consumed.
- rsp_rdata_o, out, data_width, read data (0 for writes and errors).
- rsp_error_o, out, 1, timeout flag.
- address_o, out, address_width, bus address.
- data_o, out, data_width, bus write data.
- rd_wr_o, out, 1, bus direction, 1 = write.
- data_i, in, data_width, OR-combined peripheral read data.
- take_controlr_i, in, 1, OR-combined read acknowledge.
- take_controlw_i, in, 1, OR-combined write acknowledge.
- busy_o, out, 1, high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, BUS, WAIT, RESP.

REQ-004 cmd_ready_o SHALL equal (state==IDLE); on cmd_valid_i&&cmd_ready_o the block SHALL register addr, wdata and write, then go to BUS.

REQ-005 In BUS and WAIT, address_o, data_o and rd_wr_o SHALL be driven from the registered command and held constant.

REQ-006 In IDLE and RESP, the bus SHALL be parked: address_o=IdleAddress, rd_wr_o=0, data_o=0.
- Rationale: a read of an IRQ-clear register has a side effect, so only the unmapped IdleAddress may be presented while idle.

REQ-007 BUS SHALL last exactly one cycle, then go to WAIT.
- Acknowledge inputs SHALL be ignored in BUS, because peripherals register their response one cycle after the address.

REQ-008 In WAIT, a read SHALL complete when take_controlr_i=1; a write SHALL complete when take_controlw_i=1.
- On completion: capture data_i into rsp_rdata_o (reads only; 0 for writes), set rsp_error_o=0, go to RESP.
- The opposite-direction acknowledge SHALL be ignored.

REQ-009 A WAIT cycle counter, width $clog2(TimeoutCycles+1), SHALL clear on BUS entry and increment each WAIT cycle without acknowledge.
- When the counter reaches TimeoutCycles-1 with no acknowledge: go to RESP with rsp_error_o=1, rsp_rdata_o=0.
- An acknowledge in that same cycle SHALL win over the timeout.

REQ-010 In RESP, rsp_valid_o=1 and rsp_rdata_o/rsp_error_o SHALL hold stable until rsp_ready_i=1; then go to IDLE.
- No new command SHALL be accepted in the same cycle.

REQ-011 Minimum latency SHALL be 3 cycles from the command-accept edge to rsp_valid_o=1.

REQ-012 Changes on cmd_* inputs while not in IDLE SHALL have no effect.

Reset
REQ-013 When reset_i=1 at a clock edge:
- state SHALL become IDLE;
- cmd_ready_o=1 (follows IDLE);
- rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0;
- busy_o=0 (follows IDLE);
- bus SHALL be parked per REQ-006, with the timeout counter at 0.

REQ-014 Reset mid-transaction SHALL abort it with no response generated; outputs SHALL be in reset state the cycle after the reset edge.

Structure
REQ-015 The package io_bus_pkg SHALL hold:
- the state enum bus_init_state_t {IDLE, BUS, WAIT, RESP};
- the default IdleAddress constant.

REQ-016 The design SHALL be a single module; no sub-module is natural at this size.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Read with an io_cpu instance at BaseAddress 0x9000, external inputs = 0x5A, read 0x9000 -> rsp_valid_o 3 cycles after accept, rsp_rdata_o=0x5A, rsp_error_o=0.
- Write 0x3C to 0x9001, then read 0x9001 -> ex_data_o=0x3C; read returns 0x3C, rsp_error_o=0 on both.
- Read of unmapped 0x8000 with TimeoutCycles=16 -> rsp_error_o=1, rsp_rdata_o=0; address_o=0x8000 for exactly 17 cycles (1 BUS + 16 WAIT).
- Response backpressure: rsp_ready_i low for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, cmd_ready_o=0 throughout, bus parked at 0xFFFF.
- reset_i pulsed in WAIT of a write -> next cycle state IDLE, rsp_valid_o=0, address_o=0xFFFF, rd_wr_o=0; no response is ever produced for that write.
- Idle bus with IRQ pending in io_cpu -> irq_o stays 1 because the parked address never hits IRQ_Clear.
